// File: rtl/conv_pkg.sv
// conv_pkg: shared constants and FSM encoding for the conv result collector.
//   OUT_DIM  output map side
//   NUM_FILT number of filters / maps
//   MAP_SIZE elements per map
//   DW       result width (two's complement)
//   PTR_W    read pointer width over all maps
package conv_pkg;
    localparam int OUT_DIM  = 7;
    localparam int NUM_FILT = 2;
    localparam int MAP_SIZE = OUT_DIM * OUT_DIM;
    localparam int DW       = 32;
    localparam int PTR_W    = $clog2(NUM_FILT * MAP_SIZE);
    localparam int FW       = NUM_FILT > 1 ? $clog2(NUM_FILT) : 1;
    localparam int AW       = $clog2(MAP_SIZE);
    localparam int CW       = $clog2(MAP_SIZE + 1);
    typedef enum logic {ST_COLLECT, ST_DRAIN} state_t;
endpackage

// File: rtl/ofmap_collector_bank.sv
// ofmap_bank: one output feature map - register array, write counter, full flag, async read.
//   clk, rst_n  clock, async active-low reset (clears the write counter)
//   clr_i       sync restart of the write counter
//   we_i        store wdata_i at the next raster position
//   wdata_i     value to store
//   raddr_i     raster index to read
//   rdata_o     combinational read data
//   full_o      all MAP_SIZE positions written
module ofmap_bank
    import conv_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          we_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o,
    output logic          full_o
);
    logic [DW-1:0] mem_q [MAP_SIZE];
    logic [CW-1:0] wcnt_q;
    assign full_o  = wcnt_q == CW'(MAP_SIZE);
    assign rdata_o = mem_q[raddr_i];
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) wcnt_q <= '0;
        else if (clr_i) wcnt_q <= '0;
        else if (we_i) wcnt_q <= wcnt_q + 1'b1;
    // Storage is not reset; contents are only read after being written.
    always_ff @(posedge clk)
        if (we_i) mem_q[AW'(wcnt_q)] <= wdata_i;
endmodule

// File: rtl/ofmap_collector.sv
// ofmap_collector: captures window results into per-filter maps, then drains them over valid/ready.
//   clk, rst_n           clock, async active-low reset
//   clear_i              sync restart (counters, overflow, FSM -> COLLECT)
//   y_valid_i/y_in_i     result strobe and value; filt_sel_i selects the map
//   rd_valid_o/rd_ready_i read handshake; rd_data_o/rd_filt_o element and its map
//   rd_last_o            final element of final map
//   maps_full_o          draining; overflow_o sticky dropped-result flag
//   Build option: define OFMAP_RELU_EN to clamp negative results to zero at capture.
module ofmap_collector
    import conv_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear_i,
    input  logic          y_valid_i,
    input  logic [DW-1:0] y_in_i,
    input  logic [FW-1:0] filt_sel_i,
    output logic          rd_valid_o,
    input  logic          rd_ready_i,
    output logic [DW-1:0] rd_data_o,
    output logic [FW-1:0] rd_filt_o,
    output logic          rd_last_o,
    output logic          maps_full_o,
    output logic          overflow_o
);
    state_t               state_q, state_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic                 overflow_q, overflow_d;
    logic [NUM_FILT-1:0]  full, we;
    logic [DW-1:0]        dout [NUM_FILT];
    logic [DW-1:0]        wdata;
    logic [FW-1:0]        rd_map;
    logic [AW-1:0]        rd_idx;
    logic                 drain, last, xfer, restart;
    assign drain   = state_q == ST_DRAIN;
    assign rd_map  = FW'(rd_ptr_q / PTR_W'(MAP_SIZE));
    assign rd_idx  = AW'(rd_ptr_q % PTR_W'(MAP_SIZE));
    assign last    = drain && rd_ptr_q == PTR_W'(NUM_FILT * MAP_SIZE - 1);
    assign xfer    = drain && rd_ready_i;
    assign restart = clear_i || (xfer && last);
`ifdef OFMAP_RELU_EN
    assign wdata = y_in_i[DW-1] ? '0 : y_in_i;
`else
    assign wdata = y_in_i;
`endif
    for (genvar f = 0; f < NUM_FILT; f++) begin : g_bank
        assign we[f] = y_valid_i && !drain && !clear_i && filt_sel_i == FW'(f) && !full[f];
        ofmap_bank u_bank (
            .clk     (clk),
            .rst_n   (rst_n),
            .clr_i   (restart),
            .we_i    (we[f]),
            .wdata_i (wdata),
            .raddr_i (rd_idx),
            .rdata_o (dout[f]),
            .full_o  (full[f])
        );
    end
    // Outputs are forced to zero outside DRAIN so idle reads never expose stale storage.
    assign rd_valid_o  = drain;
    assign maps_full_o = drain;
    assign rd_data_o   = drain ? dout[rd_map] : '0;
    assign rd_filt_o   = drain ? rd_map : '0;
    assign rd_last_o   = last;
    assign overflow_o  = overflow_q;
    always_comb begin
        state_d    = state_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = clear_i ? 1'b0 : overflow_q | (y_valid_i & (drain | full[filt_sel_i]));
        if (clear_i) begin
            state_d  = ST_COLLECT;
            rd_ptr_d = '0;
        end else if (xfer) begin
            state_d  = last ? ST_COLLECT : ST_DRAIN;
            rd_ptr_d = last ? '0 : rd_ptr_q + 1'b1;
        end else if (!drain && &full) begin
            state_d = ST_DRAIN;
        end
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q    <= ST_COLLECT;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
endmodule

// File: tb/tb_ofmap_collector.sv
// tb_ofmap_collector: directed/randomized checks of ofmap_collector against a map-array model.
module tb_ofmap_collector;
    logic        clk = 0, rst_n = 0, clear_i = 0, y_valid_i = 0, rd_ready_i = 0;
    logic [31:0] y_in_i = 0;
    logic [0:0]  filt_sel_i = 0;
    logic        rd_valid_o, rd_last_o, maps_full_o, overflow_o;
    logic [31:0] rd_data_o;
    logic [0:0]  rd_filt_o;
    int total = 0, bad = 0;
    logic [31:0] m [2][49];
    int wc [2];
    bit ovf;

    ofmap_collector dut (
        .clk(clk), .rst_n(rst_n), .clear_i(clear_i), .y_valid_i(y_valid_i), .y_in_i(y_in_i),
        .filt_sel_i(filt_sel_i), .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i),
        .rd_data_o(rd_data_o), .rd_filt_o(rd_filt_o), .rd_last_o(rd_last_o),
        .maps_full_o(maps_full_o), .overflow_o(overflow_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] relu(input logic [31:0] v);
`ifdef OFMAP_RELU_EN
        return v[31] ? 32'd0 : v;
`else
        return v;
`endif
    endfunction

    task automatic model_restart;
        wc[0] = 0;
        wc[1] = 0;
    endtask

    task automatic wr(input int f, input logic [31:0] v);
        y_valid_i = 1; filt_sel_i = f[0]; y_in_i = v;
        if (wc[f] < 49) begin
            m[f][wc[f]] = relu(v);
            wc[f]++;
        end else ovf = 1;
        step();
        y_valid_i = 0;
    endtask

    // mode 0: map0 = 0..48, map1 = 1000..1048; mode 1: alternating maps, random; mode 2: sequential, random
    task automatic fill(input int mode);
        int f;
        logic [31:0] v;
        for (int i = 0; i < 98; i++) begin
            f = mode == 1 ? i % 2 : i / 49;
            v = mode == 0 ? (f == 0 ? i : 1000 + i - 49) : $urandom;
            wr(f, v);
        end
    endtask

    // Waits for DRAIN with the expected 2-cycle latency, then reads beats until stop_at or the end.
    task automatic drain(input int mode, input int stop_at, input bit check_lat);
        int k = 0, cyc = 0;
        logic [31:0] stream [$];
        for (int f = 0; f < 2; f++) for (int i = 0; i < 49; i++) stream.push_back(m[f][i]);
        if (check_lat) begin
            @(negedge clk);
            chk("lat_not_yet", rd_valid_o, 0);
            step();
        end
        while (k < 98 && k != stop_at && cyc < 1000) begin
            rd_ready_i = mode == 0 ? 1'b1 : mode == 1 ? 1'((cyc % 2) == 0) : 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("rd_valid", rd_valid_o, 1);
            chk("maps_full", maps_full_o, 1);
            chk("rd_data", rd_data_o, stream[k]);
            chk("rd_filt", rd_filt_o, k / 49);
            chk("rd_last", rd_last_o, k == 97);
            @(posedge clk);
            if (rd_ready_i) k++;
            #1;
            cyc++;
        end
        rd_ready_i = 0;
        if (k != stop_at && k != 98) chk("drain_timeout", k, 98);
        if (k == 98) begin
            model_restart();
            @(negedge clk);
            chk("post_valid", rd_valid_o, 0);
            chk("post_full", maps_full_o, 0);
            chk("post_ovf", overflow_o, ovf);
            step();
        end
    endtask

    task automatic pulse_clear;
        clear_i = 1;
        step();
        clear_i = 0;
        ovf = 0;
        model_restart();
    endtask

    initial begin
        model_restart();
        ovf = 0;
        // 1: reset state, then reset again mid-collect
        step(); step();
        @(negedge clk);
        chk("rst_valid", rd_valid_o, 0); chk("rst_data", rd_data_o, 0);
        chk("rst_filt", rd_filt_o, 0);   chk("rst_last", rd_last_o, 0);
        chk("rst_full", maps_full_o, 0); chk("rst_ovf", overflow_o, 0);
        step();
        rst_n = 1;
        for (int i = 0; i < 10; i++) wr(0, $urandom);
        rst_n = 0;
        #1;
        chk("mid_rst_valid", rd_valid_o, 0);
        chk("mid_rst_ovf", overflow_o, 0);
        step();
        rst_n = 1;
        model_restart();
        // 2: raster fill with known values, full-rate drain
        fill(0);
        drain(0, -1, 1);
        // 3: interleaved maps, toggled and random backpressure
        fill(1);
        drain(1, -1, 1);
        fill(1);
        drain(2, -1, 1);
        // 4: overflow by a 50th write, and by a write during DRAIN
        for (int i = 0; i < 49; i++) wr(0, $urandom);
        wr(0, 77);
        chk("ovf_50th", overflow_o, 1);
        for (int i = 0; i < 49; i++) wr(1, $urandom);
        drain(0, -1, 1);
        pulse_clear();
        chk("ovf_cleared", overflow_o, 0);
        fill(2);
        @(negedge clk);
        step();
        y_valid_i = 1; filt_sel_i = 1; y_in_i = 55;
        step();
        y_valid_i = 0;
        ovf = 1;
        chk("ovf_drain", overflow_o, 1);
        drain(2, -1, 0);
        // 5: signed extremes, plus a write coinciding with clear
        clear_i = 1; y_valid_i = 1; filt_sel_i = 0; y_in_i = 9;
        step();
        clear_i = 0; y_valid_i = 0;
        ovf = 0;
        model_restart();
        chk("clr_ovf", overflow_o, 0);
        wr(0, -32'sd5);
        wr(0, 32'h8000_0000);
        chk("model_neg5", m[0][0], relu(32'hFFFF_FFFB));
        for (int i = 2; i < 49; i++) wr(0, $urandom);
        for (int i = 0; i < 49; i++) wr(1, $urandom);
        drain(2, -1, 1);
        // 6: clear mid-drain at element 30, then a fresh frame drains from element 0
        fill(2);
        drain(0, 30, 1);
        pulse_clear();
        @(negedge clk);
        chk("clr_valid", rd_valid_o, 0);
        chk("clr_full", maps_full_o, 0);
        step();
        fill(2);
        drain(2, -1, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
